// File: rtl/dds_sched_pkg.sv
// Shared definitions for the time-shared DDS channel scheduler:
// default sizing, FSM state encoding and the channel-index type.
package dds_sched_pkg;

    localparam int NCH_DEF = 4;  // time-shared channels (power of two, 2..8)
    localparam int PW_DEF  = 8;  // phase accumulator / tuning-word width
    localparam int LAT_DEF = 3;  // datapath issue-to-result latency

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    // Channel index at the default channel count.
    typedef logic [$clog2(NCH_DEF)-1:0] ch_idx_t;

endpackage

// File: rtl/sched_tag_delay.sv
// LAT-deep shift register carrying {valid, channel} alongside the shared
// datapath so each result can be tagged with the channel that issued it.
module sched_tag_delay #(
    parameter int LAT = 3,
    parameter int CW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    input  logic [CW-1:0] in_ch_i,
    output logic          out_valid_o,
    output logic [CW-1:0] out_ch_o
);

    logic [LAT-1:0] vld_q;
    logic [CW-1:0]  ch_q [LAT];

    // Shift the tag one stage per cycle; reset flushes in-flight tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) ch_q[i] <= '0;
        end else begin
            vld_q[0] <= in_valid_i;
            ch_q[0]  <= in_ch_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                ch_q[i]  <= ch_q[i-1];
            end
        end
    end

    assign out_valid_o = vld_q[LAT-1];
    assign out_ch_o    = ch_q[LAT-1];

endmodule

// File: rtl/dds_channel_sched.sv
// Time-shared DDS channel scheduler. One start pulse runs a frame that
// issues every channel once (0..NCH-1) to a shared sine/multiply datapath,
// advances each phase accumulator, and collects the tagged results.
// Optional build macro: SCHED_PHASE_CLR_EN -- a config write also clears
// that channel's accumulator (phase-coherent retune).
//
// Handshake: dp_valid and out_valid are pure one-cycle strobes with no
// ready/backpressure; the datapath must accept every issue and return its
// result exactly LAT cycles later, and the consumer must take out_sample
// on every cycle out_valid is high.
module dds_channel_sched
    import dds_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int PW  = PW_DEF,
    parameter int LAT = LAT_DEF,
    localparam int CW = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [CW-1:0]      cfg_ch,
    input  logic [PW-1:0]      cfg_inc,
    input  logic signed [7:0]  cfg_amp,
    input  logic               start,
    output logic               busy,
    output logic               dp_valid,
    output logic [PW-1:0]      dp_phase,
    output logic signed [7:0]  dp_mix,
    input  logic [7:0]         dp_result,
    output logic               out_valid,
    output logic [CW-1:0]      out_ch,
    output logic [7:0]         out_sample,
    output logic               frame_done,
    output sched_state_e       dbg_state
);

    sched_state_e      state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic              issue;

    logic [PW-1:0]     acc_q [NCH];
    logic [PW-1:0]     inc_q [NCH];
    logic signed [7:0] amp_q [NCH];

    logic              dp_valid_q;
    logic [PW-1:0]     dp_phase_q;
    logic signed [7:0] dp_mix_q;
    logic [CW-1:0]     dp_ch_q;

    logic              tag_valid;
    logic [CW-1:0]     tag_ch;

    logic              out_valid_q;
    logic [CW-1:0]     out_ch_q;
    logic [7:0]        out_sample_q;
    logic              frame_done_q;

    assign issue = (state_q == ST_ISSUE);

    // Frame sequencing: IDLE waits for start, ISSUE walks the channels,
    // DRAIN waits for the last tagged result before going idle again.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                end
            end
            ST_ISSUE: begin
                idx_d = idx_q + CW'(1);
                if (idx_q == CW'(NCH - 1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (frame_done_q) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // FSM state and issue index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Per-channel tuning, amplitude and accumulator storage. Reads for the
    // issue see the pre-edge values, so a same-cycle config write only takes
    // effect from the next issue of that channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= '0;
                amp_q[i] <= '0;
            end
        end else begin
            if (cfg_we) begin
                inc_q[cfg_ch] <= cfg_inc;
                amp_q[cfg_ch] <= cfg_amp;
            end
            if (issue) acc_q[idx_q] <= acc_q[idx_q] + inc_q[idx_q];
`ifdef SCHED_PHASE_CLR_EN
            // Retune clears the phase; placed last so it beats the advance.
            if (cfg_we) acc_q[cfg_ch] <= '0;
`endif
        end
    end

    // Registered datapath operands; phase/mix hold outside ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid_q <= 1'b0;
            dp_phase_q <= '0;
            dp_mix_q   <= '0;
            dp_ch_q    <= '0;
        end else begin
            dp_valid_q <= issue;
            if (issue) begin
                dp_phase_q <= acc_q[idx_q];
                dp_mix_q   <= amp_q[idx_q];
                dp_ch_q    <= idx_q;
            end
        end
    end

    sched_tag_delay #(
        .LAT (LAT),
        .CW  (CW)
    ) u_tag_delay (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (dp_valid_q),
        .in_ch_i     (dp_ch_q),
        .out_valid_o (tag_valid),
        .out_ch_o    (tag_ch)
    );

    // Capture the datapath result against its tag; flag the last channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_sample_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= tag_valid;
            frame_done_q <= tag_valid && (tag_ch == CW'(NCH - 1));
            if (tag_valid) begin
                out_ch_q     <= tag_ch;
                out_sample_q <= dp_result;
            end
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign dp_valid   = dp_valid_q;
    assign dp_phase   = dp_phase_q;
    assign dp_mix     = dp_mix_q;
    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_sample = out_sample_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dds_channel_sched.sv
// Directed bench for dds_channel_sched with a stub datapath that returns
// dp_phase delayed by LAT cycles. Optional build macro: SCHED_PHASE_CLR_EN.
module tb_dds_channel_sched;
    import dds_sched_pkg::*;

    localparam int LAT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [7:0]        cfg_inc;
    logic signed [7:0] cfg_amp;
    logic              start;
    logic              busy;
    logic              dp_valid;
    logic [7:0]        dp_phase;
    logic signed [7:0] dp_mix;
    logic [7:0]        dp_result;
    logic              out_valid;
    logic [1:0]        out_ch;
    logic [7:0]        out_sample;
    logic              frame_done;
    sched_state_e      dbg_state;

    dds_channel_sched #(.NCH(4), .PW(8), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_amp    (cfg_amp),
        .start      (start),
        .busy       (busy),
        .dp_valid   (dp_valid),
        .dp_phase   (dp_phase),
        .dp_mix     (dp_mix),
        .dp_result  (dp_result),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_sample (out_sample),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // Stub datapath: result = phase operand, LAT cycles later.
    logic [7:0] dp_pipe [LAT];
    always @(posedge clk) begin
        dp_pipe[0] <= dp_phase;
        for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_result = dp_pipe[LAT-1];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Hand-computed expected issue phases / mix per frame.
    // ch0 inc 10, ch1 inc F0 (wraps), ch2 inc 05 (then 01 from frame 4), ch3 inc 33.
    logic [7:0] exp_phase_t [7][4];
    logic [7:0] exp_mix_t   [7][4];

    // Per-frame capture
    logic [7:0] cap_phase[$];
    logic [7:0] cap_mix[$];
    logic [7:0] cap_sample[$];
    int         cap_och[$];
    int         cap_ocyc[$];
    int iss_first, out_first, fd_cycle, fd_ch, n_fd, busy_fall;

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input logic [1:0] ch, input logic [7:0] inc, input logic [7:0] amp);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = ch; cfg_inc = inc; cfg_amp = amp;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Pulse start, then observe on each falling edge (cycle k after start
    // was driven) until busy drops. Optionally re-pulse start at restart_k
    // and/or write config at cfg_k.
    task automatic run_frame(input int restart_k, input int cfg_k, input logic [1:0] c_ch,
                             input logic [7:0] c_inc, input logic [7:0] c_amp);
        cap_phase.delete(); cap_mix.delete(); cap_sample.delete();
        cap_och.delete(); cap_ocyc.delete();
        iss_first = -1; out_first = -1; fd_cycle = -1; fd_ch = -1; n_fd = 0; busy_fall = -1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dp_valid) begin
                if (iss_first < 0) iss_first = k;
                cap_phase.push_back(dp_phase);
                cap_mix.push_back(dp_mix);
            end
            if (out_valid) begin
                if (out_first < 0) out_first = k;
                cap_och.push_back(int'(out_ch));
                cap_sample.push_back(out_sample);
                cap_ocyc.push_back(k);
            end
            if (frame_done) begin
                n_fd++;
                fd_cycle = k;
                fd_ch = int'(out_ch);
            end
            start  = (k == restart_k);
            cfg_we = (k == cfg_k);
            cfg_ch = c_ch; cfg_inc = c_inc; cfg_amp = c_amp;
            if (!busy) begin
                busy_fall = k;
                break;
            end
        end
        start = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic frame_checks(input int f);
        logic [7:0] e;
        check($sformatf("f%0d_end", f), busy_fall >= 0, 1);
        check($sformatf("f%0d_n_iss", f), cap_phase.size(), 4);
        check($sformatf("f%0d_iss_first", f), iss_first, 2);
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("f%0d_phase%0d", f, ch),
                  (ch < cap_phase.size()) ? {24'h0, cap_phase[ch]} : 32'hDEAD, exp_phase_t[f][ch]);
            check($sformatf("f%0d_mix%0d", f, ch),
                  (ch < cap_mix.size()) ? {24'h0, cap_mix[ch]} : 32'hDEAD, exp_mix_t[f][ch]);
        end
        check($sformatf("f%0d_n_out", f), cap_och.size(), 4);
        check($sformatf("f%0d_out_first", f), out_first, 6);
        for (int ch = 0; ch < 4; ch++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            check($sformatf("f%0d_out_ch%0d", f, ch),
                  (ch < cap_och.size()) ? cap_och[ch] : 32'hDEAD, ch);
            check($sformatf("f%0d_out_cyc%0d", f, ch),
                  (ch < cap_ocyc.size()) ? cap_ocyc[ch] : 32'hDEAD, 6 + ch);
            check($sformatf("f%0d_sample%0d", f, ch),
                  (ch < cap_sample.size()) ? {24'h0, cap_sample[ch]} : 32'hDEAD, e);
        end
        check($sformatf("f%0d_n_fd", f), n_fd, 1);
        check($sformatf("f%0d_fd_cycle", f), fd_cycle, 9);
        check($sformatf("f%0d_fd_ch", f), fd_ch, 3);
        check($sformatf("f%0d_busy_fall", f), busy_fall, 10);
        check($sformatf("f%0d_dp_valid_idle", f), dp_valid, 0);
        check($sformatf("f%0d_dp_phase_hold", f), dp_phase, exp_phase_t[f][3]);
        check($sformatf("f%0d_state_idle", f), dbg_state, ST_IDLE);
    endtask

    task automatic do_frame(input int f, input int restart_k, input int cfg_k, input logic [1:0] c_ch,
                            input logic [7:0] c_inc, input logic [7:0] c_amp);
        for (int ch = 0; ch < 4; ch++) exp_q.push_back(exp_phase_t[f][ch]);
        run_frame(restart_k, cfg_k, c_ch, c_inc, c_amp);
        frame_checks(f);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int cnt_ov, cnt_fd, cnt_dv, cnt_busy;

    initial begin
        exp_phase_t[0] = '{8'h00, 8'h00, 8'h00, 8'h00};
        exp_phase_t[1] = '{8'h10, 8'hF0, 8'h05, 8'h33};
        exp_phase_t[2] = '{8'h20, 8'hE0, 8'h0A, 8'h66};
        exp_phase_t[3] = '{8'h30, 8'hD0, 8'h0F, 8'h99};
        exp_phase_t[4] = '{8'h40, 8'hC0, 8'h14, 8'hCC};
`ifdef SCHED_PHASE_CLR_EN
        exp_phase_t[5] = '{8'h50, 8'hB0, 8'h00, 8'hFF};
`else
        exp_phase_t[5] = '{8'h50, 8'hB0, 8'h19, 8'hFF};
`endif
        exp_phase_t[6] = '{8'h00, 8'h00, 8'h00, 8'h00};
        for (int f = 0; f < 5; f++) exp_mix_t[f] = '{8'h40, 8'h11, 8'h22, 8'h80};
        exp_mix_t[5] = '{8'h40, 8'h11, 8'h55, 8'h80};
        exp_mix_t[6] = '{8'h00, 8'h00, 8'h00, 8'h00};

        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_amp = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_dp_valid", dp_valid, 0);
        check("rst_dp_phase", dp_phase, 0);
        check("rst_dp_mix", dp_mix, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sample", out_sample, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b0;

        cfg_write(2'd0, 8'h10, 8'h40);
        cfg_write(2'd1, 8'hF0, 8'h11);
        cfg_write(2'd2, 8'h05, 8'h22);
        cfg_write(2'd3, 8'h33, 8'h80);

        do_frame(0, 0, 0, 2'd0, 8'h00, 8'h00);
        do_frame(1, 0, 0, 2'd0, 8'h00, 8'h00);
        do_frame(2, 0, 0, 2'd0, 8'h00, 8'h00);

        // Start pulsed during DRAIN must be ignored.
        do_frame(3, 7, 0, 2'd0, 8'h00, 8'h00);
        cnt_dv = 0; cnt_busy = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dp_valid) cnt_dv++;
            if (busy) cnt_busy++;
        end
        check("drain_start_dv", cnt_dv, 0);
        check("drain_start_busy", cnt_busy, 0);

        // Config write to ch2 in the same cycle as its issue.
        do_frame(4, 0, 3, 2'd2, 8'h01, 8'h55);
        do_frame(5, 0, 0, 2'd0, 8'h00, 8'h00);

        // Reset during ISSUE with idx=2.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_dv", dp_valid, 1);
        check("pre_rst_phase", dp_phase, 8'hA0);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dv", dp_valid, 0);
        check("mid_rst_phase", dp_phase, 0);
        check("mid_rst_mix", dp_mix, 0);
        check("mid_rst_ov", out_valid, 0);
        check("mid_rst_fd", frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt_ov = 0; cnt_fd = 0; cnt_dv = 0; cnt_busy = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid) cnt_ov++;
            if (frame_done) cnt_fd++;
            if (dp_valid) cnt_dv++;
            if (busy) cnt_busy++;
        end
        check("post_rst_ov", cnt_ov, 0);
        check("post_rst_fd", cnt_fd, 0);
        check("post_rst_dv", cnt_dv, 0);
        check("post_rst_busy", cnt_busy, 0);

        // Fresh frame after reset: all channel state back to zero.
        do_frame(6, 0, 0, 2'd0, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
